// File: rtl/xadc_drp_responder_if.sv
// DRP bus bundle between a DRP master (monitor/readout logic or bench) and
// the xadc_drp_responder.
//   DEN    : enable, single-cycle pulse, master -> slave
//   DWE    : write enable, sampled with DEN
//   DADDR  : 7-bit register address, sampled with DEN
//   DI     : 16-bit write data, sampled with DEN
//   DO     : 16-bit read data, valid only while DRDY=1, slave -> master
//   DRDY   : one-cycle transaction-complete pulse, slave -> master
interface xadc_drp_responder_if;
  logic        DEN;
  logic        DWE;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (output DEN, output DWE, output DADDR, output DI,
                  input  DO,  input  DRDY);
  modport slave  (input  DEN, input  DWE, input  DADDR, input  DI,
                  output DO,  output DRDY);
endinterface

// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: stands in for the XADC primitive on the DRP bus.
// Serves DRP reads/writes of a small register file and runs a fixed
// 7-channel conversion sequence that loads the externally supplied sample
// words (low nibble cleared) into the status registers.
//
// Ports:
//   DCLK, RESET        : clock, synchronous active-high reset
//   drp (slave)        : DEN/DWE/DADDR/DI in, DO/DRDY out
//   BUSY/EOC/EOS       : conversion in progress / end-of-conversion /
//                        end-of-sequence strobes
//   CHANNEL            : address of the last completed conversion
//   SMP_*              : 16-bit sample sources, one per sequence slot
//   DRP_ERR            : sticky protocol error
//
// Build option: define XADC_DRP_RESP_PROTOCOL_CHECK_EN to build the DRP
// protocol checker behind DRP_ERR; otherwise DRP_ERR is tied low.
module xadc_drp_responder #(
  parameter int DRDY_LAT    = 2,
  parameter int CONV_CYCLES = 26
) (
  input  logic                  DCLK,
  input  logic                  RESET,
  xadc_drp_responder_if.slave   drp,
  output logic                  BUSY,
  output logic                  EOC,
  output logic                  EOS,
  output logic [4:0]            CHANNEL,
  input  logic [15:0]           SMP_TEMP,
  input  logic [15:0]           SMP_VCCINT,
  input  logic [15:0]           SMP_VCCBRAM,
  input  logic [15:0]           SMP_AUX6,
  input  logic [15:0]           SMP_AUX7,
  input  logic [15:0]           SMP_AUX14,
  input  logic [15:0]           SMP_AUX15,
  output logic                  DRP_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} seq_state_t;

  // Register address of each slot of the conversion sequence.
  function automatic logic [4:0] ch_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    ch_addr = 5'h00;
      3'd1:    ch_addr = 5'h01;
      3'd2:    ch_addr = 5'h06;
      3'd3:    ch_addr = 5'h16;
      3'd4:    ch_addr = 5'h17;
      3'd5:    ch_addr = 5'h1E;
      3'd6:    ch_addr = 5'h1F;
      default: ch_addr = 5'h00;
    endcase
  endfunction

  // XADC results are 12 bits, MSB-justified in the 16-bit register.
  function automatic logic [15:0] quantize(input logic [15:0] s);
    quantize = s & 16'hFFF0;
  endfunction

  seq_state_t  state_q, state_d;
  logic [7:0]  conv_cnt_q, conv_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [4:0]  chan_q, chan_d;
  logic [15:0] stat_q [7];
  logic [15:0] cfg0_q, cfg1_q, cfg2_q;
  logic [3:0]  lat_cnt_q;
  logic [15:0] rdata_q;
  logic [15:0] smp_sel;
  logic [15:0] rd_val;
  logic        seq_en;
  logic        accept;

  assign seq_en = (cfg1_q[15:12] != 4'h0);
  // A transaction is outstanding up to and including its DRDY cycle.
  assign accept = drp.DEN && (lat_cnt_q == 4'd0);

  always_comb begin
    case (idx_q)
      3'd0:    smp_sel = SMP_TEMP;
      3'd1:    smp_sel = SMP_VCCINT;
      3'd2:    smp_sel = SMP_VCCBRAM;
      3'd3:    smp_sel = SMP_AUX6;
      3'd4:    smp_sel = SMP_AUX7;
      3'd5:    smp_sel = SMP_AUX14;
      default: smp_sel = SMP_AUX15;
    endcase
  end

  // Sequencer: state register
  always_ff @(posedge DCLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge DCLK) begin
    if (RESET) begin
      conv_cnt_q <= 8'd0;
      idx_q      <= 3'd0;
      chan_q     <= 5'd0;
    end else begin
      conv_cnt_q <= conv_cnt_d;
      idx_q      <= idx_d;
      chan_q     <= chan_d;
    end
  end

  // Sequencer: next state
  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    idx_d      = idx_q;
    chan_d     = chan_q;
    case (state_q)
      S_IDLE: begin
        if (seq_en) begin
          state_d    = S_CONVERT;
          conv_cnt_d = 8'd0;
        end
      end
      S_CONVERT: begin
        if (conv_cnt_q == 8'(CONV_CYCLES - 1)) state_d = S_UPDATE;
        else conv_cnt_d = conv_cnt_q + 8'd1;
      end
      S_UPDATE: begin
        chan_d = ch_addr(idx_q);
        idx_d  = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
        // Enable is only looked at here, so a halt lets the running
        // conversion finish and keeps idx for the resume.
        if (seq_en) begin
          state_d    = S_CONVERT;
          conv_cnt_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer: outputs
  always_comb begin
    BUSY    = (state_q == S_CONVERT);
    EOC     = (state_q == S_UPDATE);
    EOS     = (state_q == S_UPDATE) && (idx_q == 3'd6);
    CHANNEL = (state_q == S_UPDATE) ? ch_addr(idx_q) : chan_q;
  end

  always_ff @(posedge DCLK) begin
    for (int i = 0; i < 7; i++) begin
      if (RESET) stat_q[i] <= 16'h0000;
      else if (state_q == S_UPDATE && idx_q == 3'(i)) stat_q[i] <= quantize(smp_sel);
    end
  end

  // Read mux; only seven of the 64 status locations are ever non-zero.
  always_comb begin
    rd_val = 16'h0000;
    if (drp.DADDR[6] == 1'b0) begin
      for (int i = 0; i < 7; i++) begin
        if (drp.DADDR[5] == 1'b0 && drp.DADDR[4:0] == ch_addr(3'(i))) rd_val = stat_q[i];
      end
    end else begin
      case (drp.DADDR)
        7'h40:   rd_val = cfg0_q;
        7'h41:   rd_val = cfg1_q;
        7'h42:   rd_val = cfg2_q;
        default: rd_val = 16'h0000;
      endcase
    end
  end

  // DRP: accept, latency countdown, config writes
  always_ff @(posedge DCLK) begin
    if (RESET) begin
      lat_cnt_q <= 4'd0;
      cfg0_q    <= 16'h0000;
      cfg1_q    <= 16'h2000;
      cfg2_q    <= 16'h0000;
    end else if (accept) begin
      lat_cnt_q <= 4'(DRDY_LAT);
      if (drp.DWE) begin
        case (drp.DADDR)
          7'h40:   cfg0_q <= drp.DI;
          7'h41:   cfg1_q <= drp.DI;
          7'h42:   cfg2_q <= drp.DI;
          default: ;
        endcase
      end
    end else if (lat_cnt_q != 4'd0) begin
      lat_cnt_q <= lat_cnt_q - 4'd1;
    end
  end

  // Captured read data; reads see register contents before this edge.
  always_ff @(posedge DCLK) begin
    if (accept) rdata_q <= drp.DWE ? 16'h0000 : rd_val;
  end

  assign drp.DRDY = (lat_cnt_q == 4'd1);
  assign drp.DO   = (lat_cnt_q == 4'd1) ? rdata_q : 16'h0000;

`ifdef XADC_DRP_RESP_PROTOCOL_CHECK_EN
  logic err_q;
  always_ff @(posedge DCLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if ((drp.DEN && lat_cnt_q != 4'd0) ||
                 (drp.DWE && !drp.DEN) ||
                 (drp.DEN && drp.DADDR > 7'h42)) begin
      err_q <= 1'b1;
    end
  end
  assign DRP_ERR = err_q;
`else
  assign DRP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Randomized bench for xadc_drp_responder with an event-level reference
// model: conversions are scheduled as "next EOC at cycle N", DRP
// transactions as "accepted at cycle T, completes at T+LAT".
module tb_xadc_drp_responder;
  localparam int LAT  = 2;
  localparam int CONV = 26;

  logic        DCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        BUSY, EOC, EOS, DRP_ERR;
  logic [4:0]  CHANNEL;
  logic [15:0] smp [7];

  always #5 DCLK = ~DCLK;

  xadc_drp_responder_if bus();

  xadc_drp_responder #(.DRDY_LAT(LAT), .CONV_CYCLES(CONV)) dut (
    .DCLK(DCLK), .RESET(RESET), .drp(bus.slave),
    .BUSY(BUSY), .EOC(EOC), .EOS(EOS), .CHANNEL(CHANNEL),
    .SMP_TEMP(smp[0]), .SMP_VCCINT(smp[1]), .SMP_VCCBRAM(smp[2]),
    .SMP_AUX6(smp[3]), .SMP_AUX7(smp[4]), .SMP_AUX14(smp[5]),
    .SMP_AUX15(smp[6]), .DRP_ERR(DRP_ERR)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit rand_smp = 1'b0;

  logic [6:0] ADDR_TAB [7] = '{7'h00, 7'h01, 7'h06, 7'h16, 7'h17, 7'h1E, 7'h1F};

  // reference model state
  logic [15:0] m_stat [7];
  logic [15:0] m_cfg [3];
  int          m_next_eoc;
  int          m_idx;
  logic [4:0]  m_last;
  bit          m_pend;
  int          m_ta;
  logic [15:0] m_cap;
  bit          m_err;

  // directed-observation bookkeeping
  int rel_cyc = 0;
  int first_eoc = -1;
  int first_eos = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_stat[i] = 16'h0000;
    m_cfg[0] = 16'h0000; m_cfg[1] = 16'h2000; m_cfg[2] = 16'h0000;
    m_next_eoc = -1; m_idx = 0; m_last = 5'd0;
    m_pend = 1'b0; m_ta = 0; m_cap = 16'h0000; m_err = 1'b0;
  endtask

  function automatic logic [15:0] model_read(input logic [6:0] a);
    logic [15:0] v = 16'h0000;
    for (int i = 0; i < 7; i++) if (a == ADDR_TAB[i]) v = m_stat[i];
    if (a == 7'h40) v = m_cfg[0];
    if (a == 7'h41) v = m_cfg[1];
    if (a == 7'h42) v = m_cfg[2];
    return v;
  endfunction

  // One DCLK cycle: drive inputs after the edge, check at the falling edge,
  // then advance the model across the next rising edge.
  task automatic do_cycle(input bit rst, input bit den, input bit dwe,
                          input logic [6:0] a, input logic [15:0] di);
    bit exp_drdy, exp_eoc, exp_busy, exp_eos, outstanding, en;
    logic [4:0] exp_ch;
    @(posedge DCLK);
    #1;
    RESET = rst;
    bus.DEN = den; bus.DWE = dwe; bus.DADDR = a; bus.DI = di;
    if (rand_smp)
      for (int i = 0; i < 7; i++) if ($urandom_range(0, 3) == 0) smp[i] = 16'($urandom);
    @(negedge DCLK);

    exp_drdy = m_pend && (cyc == m_ta + LAT);
    exp_eoc  = (cyc == m_next_eoc);
    exp_busy = (m_next_eoc >= 0) && (cyc >= m_next_eoc - CONV) && (cyc < m_next_eoc);
    exp_eos  = exp_eoc && (m_idx == 6);
    exp_ch   = exp_eoc ? ADDR_TAB[m_idx][4:0] : m_last;
    check("DRDY", bus.DRDY, exp_drdy);
    check("DO", bus.DO, exp_drdy ? m_cap : 16'h0000);
    check("BUSY", BUSY, exp_busy);
    check("EOC", EOC, exp_eoc);
    check("EOS", EOS, exp_eos);
    check("CHANNEL", CHANNEL, exp_ch);
`ifdef XADC_DRP_RESP_PROTOCOL_CHECK_EN
    check("DRP_ERR", DRP_ERR, m_err);
`else
    check("DRP_ERR", DRP_ERR, 1'b0);
`endif
    if (EOC === 1'b1 && first_eoc < 0) first_eoc = cyc - rel_cyc;
    if (EOS === 1'b1 && first_eos < 0) first_eos = cyc - rel_cyc;

    if (rst) begin
      model_reset();
    end else begin
      en = (m_cfg[1][15:12] != 4'h0);
      outstanding = m_pend;
      if (exp_drdy) m_pend = 1'b0;
      if ((den && outstanding) || (dwe && !den) || (den && a > 7'h42)) m_err = 1'b1;
      if (den && !outstanding) begin
        m_pend = 1'b1;
        m_ta   = cyc;
        m_cap  = dwe ? 16'h0000 : model_read(a);
        if (dwe && a >= 7'h40 && a <= 7'h42) m_cfg[a - 7'h40] = di;
      end
      if (exp_eoc) begin
        m_stat[m_idx] = smp[m_idx] & 16'hFFF0;
        m_last = ADDR_TAB[m_idx][4:0];
        m_idx = (m_idx + 1) % 7;
        m_next_eoc = en ? cyc + CONV + 1 : -1;
      end else if (m_next_eoc < 0 && en) begin
        m_next_eoc = cyc + CONV + 1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);
  endtask

  task automatic rand_cycle();
    bit den, dwe;
    logic [6:0] a;
    logic [15:0] di;
    int r;
    den = ($urandom_range(0, 2) == 0);
    dwe = den ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
    r = $urandom_range(0, 9);
    if (r < 7)       a = ADDR_TAB[r];
    else if (r == 7) a = 7'($urandom_range(0, 63));
    else if (r == 8) a = 7'($urandom_range(64, 66));
    else             a = 7'($urandom_range(67, 127));
    di = 16'($urandom);
    if (a == 7'h41) begin
      if ($urandom_range(0, 3) == 0) di[15:12] = 4'h0;
      else if (di[15:12] == 4'h0) di[15:12] = 4'h2;
    end
    do_cycle(1'b0, den, dwe, a, di);
  endtask

  initial begin
    bus.DEN = 1'b0; bus.DWE = 1'b0; bus.DADDR = 7'h00; bus.DI = 16'h0000;
    for (int i = 0; i < 7; i++) smp[i] = 16'h0000;
    smp[0] = 16'hABCD;
    smp[6] = 16'h1234;
    model_reset();

    // reset, then directed walk through one full sequence
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0000);
    rel_cyc = cyc;
    do_cycle(1'b0, 1'b1, 1'b0, 7'h00, 16'h0000);   // read 0x00 before first EOC
    idle(27);
    do_cycle(1'b0, 1'b1, 1'b0, 7'h00, 16'h0000);   // read 0x00 -> 0xABC0
    idle(3);
    do_cycle(1'b0, 1'b1, 1'b0, 7'h40, 16'h0000);   // back-to-back DEN
    do_cycle(1'b0, 1'b1, 1'b0, 7'h40, 16'h0000);
    idle(3);
    do_cycle(1'b0, 1'b1, 1'b1, 7'h40, 16'h03FF);
    idle(2);
    do_cycle(1'b0, 1'b1, 1'b0, 7'h40, 16'h0000);
    idle(2);
    do_cycle(1'b0, 1'b1, 1'b1, 7'h00, 16'hFFFF);
    idle(2);
    do_cycle(1'b0, 1'b1, 1'b0, 7'h00, 16'h0000);
    idle(150);
    do_cycle(1'b0, 1'b1, 1'b0, 7'h1F, 16'h0000);   // read AUX15 -> 0x1230
    idle(3);
    check("first_eoc_cycle", 32'(first_eoc), 32'd27);
    check("first_eos_cycle", 32'(first_eos), 32'd189);

    // randomized traffic, including CFG1 halts and resumes
    rand_smp = 1'b1;
    for (int i = 0; i < 2500; i++) rand_cycle();

    // reset one cycle after an accepted read: the transaction is dropped
    do_cycle(1'b0, 1'b1, 1'b0, 7'h41, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0000);
    for (int i = 0; i < 1200; i++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
